mem_stream_reader: RTL

//  Downstream consumer of the address counter. On a start request it walks a

---
 rtl/mem_stream_pkg.sv | 18 +
 rtl/addr_counter.sv | 28 ++
 rtl/mem_stream_reader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory stream reader: FSM state encoding and
// the counter-width helper.
package mem_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One spare bit so the counter can represent LENGTH itself without wrapping.
  function automatic int addr_width(input int length);
    return $clog2(length) + 1;
  endfunction

endpackage

// File: rtl/addr_counter.sv
// Address counter for the stream reader: synchronous clear, count enable and
// a terminal flag raised once the value reaches LENGTH-1.
module addr_counter #(
  parameter int LENGTH = 64,
  parameter int ADDR_W = $clog2(LENGTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] value,
  output logic              last
);

  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  assign value = cnt_q;
  assign last  = (cnt_q >= ADDR_W'(LENGTH - 1));

endmodule

// File: rtl/mem_stream_reader.sv
// Walks a synchronous-read memory from address 0 to LENGTH-1 and emits each
// word on a valid/ready stream. Optional STREAM_CHECKSUM_EN adds a checksum port.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter  int LENGTH = 64,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = addr_width(LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef STREAM_CHECKSUM_EN
  ,output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);

  state_t            state_q, state_d;
  logic              cnt_clr, cnt_en, cnt_last, capture;
  logic [DATA_W-1:0] data_p1;

  addr_counter #(
    .LENGTH (LENGTH),
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .value (mem_addr),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    capture   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_clr = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_rd_en = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        capture = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // The final word leaves the counter at LENGTH-1 so it never wraps.
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_en  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data stage: memory word lands one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
    end else if (capture) begin
      data_p1 <= mem_rdata;
    end
  end

  assign out_data = data_p1;

`ifdef STREAM_CHECKSUM_EN
  logic                     hs;
  logic [DATA_W+ADDR_W-1:0] sum_q;

  assign hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sum_q <= '0;
    end else if (hs) begin
      sum_q <= sum_q + {{ADDR_W{1'b0}}, data_p1};
    end
  end

  assign checksum = sum_q;
`endif

endmodule
